// File: rtl/fifo_flush_arbiter_if.sv
// ============================================================================
// Module      : fifo_flush_arbiter_if
// Description : Bundles the signals around fifo_flush_arbiter into one port.
//               This covers the producer write side, the consumer read side,
//               the flush request, status, and the FIFO control/data lines.
//               slave  : view used by the arbiter itself.
//               master : view used by the surrounding logic / testbench.
//               Macro FIFO_FLUSH_ARB_PERF_EN adds perf_stall_cnt and
//               perf_flush_cnt (arbiter outputs).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_flush_arbiter_if #(
    parameter int REQ_NUM  = 4,
    parameter int ID_W     = 2,
    parameter int DATA_LEN = 32
);
    logic                         flush_req;
    logic [REQ_NUM-1:0]           req_valid;
    logic [REQ_NUM*DATA_LEN-1:0]  req_data;
    logic [REQ_NUM-1:0]           req_ready;
    logic [ID_W-1:0]              grant_id;
    logic                         out_valid;
    logic [DATA_LEN-1:0]          out_data;
    logic                         out_ready;
    logic                         busy;
    logic                         fifo_wen;
    logic [DATA_LEN-1:0]          fifo_wdata;
    logic                         fifo_ren;
    logic                         fifo_flush;
    logic [DATA_LEN-1:0]          fifo_rdata;
    logic                         fifo_full;
    logic                         fifo_empty;
`ifdef FIFO_FLUSH_ARB_PERF_EN
    logic [31:0]                  perf_stall_cnt;
    logic [15:0]                  perf_flush_cnt;

    modport slave (
        input  flush_req, req_valid, req_data, out_ready,
               fifo_rdata, fifo_full, fifo_empty,
        output req_ready, grant_id, out_valid, out_data, busy,
               fifo_wen, fifo_wdata, fifo_ren, fifo_flush,
               perf_stall_cnt, perf_flush_cnt
    );

    modport master (
        output flush_req, req_valid, req_data, out_ready,
               fifo_rdata, fifo_full, fifo_empty,
        input  req_ready, grant_id, out_valid, out_data, busy,
               fifo_wen, fifo_wdata, fifo_ren, fifo_flush,
               perf_stall_cnt, perf_flush_cnt
    );
`else
    modport slave (
        input  flush_req, req_valid, req_data, out_ready,
               fifo_rdata, fifo_full, fifo_empty,
        output req_ready, grant_id, out_valid, out_data, busy,
               fifo_wen, fifo_wdata, fifo_ren, fifo_flush
    );

    modport master (
        output flush_req, req_valid, req_data, out_ready,
               fifo_rdata, fifo_full, fifo_empty,
        input  req_ready, grant_id, out_valid, out_data, busy,
               fifo_wen, fifo_wdata, fifo_ren, fifo_flush
    );
`endif

endinterface

`default_nettype wire

// File: rtl/fifo_flush_arbiter.sv
// ============================================================================
// Module      : fifo_flush_arbiter
// Description : Round-robin write-port arbiter and flush sequencer for one
//               fifo_with_flush instance.
//               REQ_NUM valid/ready producers share the FIFO write port.
//               The FIFO read side is presented as valid/ready.
//               A flush request becomes a clean FLUSH/HOLD sequence, so no
//               push or pop coincides with the flush.
//   clk  : clock
//   rst  : synchronous reset, active-high
//   bus  : fifo_flush_arbiter_if.slave. It carries these signals:
//          flush_req, req_valid/req_data/req_ready, grant_id,
//          out_valid/out_data/out_ready, busy,
//          fifo_wen/fifo_wdata/fifo_ren/fifo_flush,
//          fifo_rdata/fifo_full/fifo_empty
//   Optional macro FIFO_FLUSH_ARB_PERF_EN adds two counters:
//          perf_stall_cnt (cycles with a producer waiting and no write)
//          perf_flush_cnt (entries into FLUSH)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_flush_arbiter #(
    parameter int REQ_NUM    = 4,
    parameter int ID_W       = 2,
    parameter int DATA_LEN   = 32,
    parameter int FLUSH_HOLD = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    fifo_flush_arbiter_if.slave    bus
);

    localparam logic [1:0] c_RUN       = 2'd0;
    localparam logic [1:0] c_FLUSH     = 2'd1;
    localparam logic [1:0] c_HOLD      = 2'd2;
    localparam logic [3:0] c_HOLD_LOAD = 4'(FLUSH_HOLD);
    localparam logic [ID_W-1:0] c_LAST_ID = ID_W'(REQ_NUM - 1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [3:0]          r_hold_cnt;
    logic [3:0]          w_hold_nxt;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     w_grant;
    logic [ID_W:0]       w_idx;
    logic                w_found;
    logic                w_run;
    logic                w_wen;
    logic                w_out_valid;
    logic [REQ_NUM-1:0]  w_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_RUN;
            r_hold_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. A flush request has priority in every state.
    // A request that arrives during HOLD restarts the whole sequence.
    // hold_cnt counts the HOLD cycles that remain, including the current one.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        if (bus.flush_req) begin
            w_state_nxt = c_FLUSH;
            w_hold_nxt  = c_HOLD_LOAD;
        end else begin
            case (r_state)
                c_RUN: begin
                    w_state_nxt = c_RUN;
                end
                c_FLUSH: begin
                    w_state_nxt = (c_HOLD_LOAD == 4'd0) ? c_RUN : c_HOLD;
                end
                c_HOLD: begin
                    if (r_hold_cnt <= 4'd1) begin
                        w_state_nxt = c_RUN;
                        w_hold_nxt  = 4'd0;
                    end else begin
                        w_hold_nxt  = r_hold_cnt - 4'd1;
                    end
                end
                default: begin
                    w_state_nxt = c_RUN;
                    w_hold_nxt  = 4'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Round-robin grant. The search starts at rr_ptr and wraps modulo
    // REQ_NUM. The extra index bit lets the wrap subtraction work when
    // REQ_NUM is not a power of two.
    // ------------------------------------------------------------------
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_idx >= (ID_W+1)'(REQ_NUM)) begin
                w_idx = w_idx - (ID_W+1)'(REQ_NUM);
            end
            if (!w_found && bus.req_valid[w_idx[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_idx[ID_W-1:0];
            end
        end
    end

    // A same-cycle flush request already blocks traffic, before the state changes.
    assign w_run       = (r_state == c_RUN) && !bus.flush_req;
    assign w_wen       = w_run && !bus.fifo_full && (|bus.req_valid);
    assign w_out_valid = w_run && !bus.fifo_empty;

    always_comb begin
        w_ready = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            w_ready[i] = w_wen && (w_grant == ID_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_wen) begin
            r_rr_ptr <= (w_grant == c_LAST_ID) ? '0 : w_grant + ID_W'(1);
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.grant_id   = w_grant;
    assign bus.fifo_wen   = w_wen;
    assign bus.fifo_wdata = bus.req_data[w_grant*DATA_LEN +: DATA_LEN];
    assign bus.out_valid  = w_out_valid;
    assign bus.out_data   = bus.fifo_rdata;
    assign bus.fifo_ren   = w_out_valid && bus.out_ready;
    assign bus.fifo_flush = (r_state == c_FLUSH);
    assign bus.busy       = (r_state != c_RUN);

`ifdef FIFO_FLUSH_ARB_PERF_EN
    logic [31:0] r_perf_stall_cnt;
    logic [15:0] r_perf_flush_cnt;

    // Both counters wrap silently, and a flush does not clear them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall_cnt <= 32'd0;
            r_perf_flush_cnt <= 16'd0;
        end else begin
            if ((|bus.req_valid) && !w_wen) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            end
            if ((w_state_nxt == c_FLUSH) && (r_state != c_FLUSH)) begin
                r_perf_flush_cnt <= r_perf_flush_cnt + 16'd1;
            end
        end
    end

    assign bus.perf_stall_cnt = r_perf_stall_cnt;
    assign bus.perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_flush_arbiter.sv
// ============================================================================
// Module      : tb_fifo_flush_arbiter
// Description : Directed self-checking bench for fifo_flush_arbiter.
//               The arbiter is connected to a small depth-8 FIFO model.
//               This model reports full at occupancy 7 and clears on
//               fifo_flush or rst.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_flush_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    fifo_flush_arbiter_if #(.REQ_NUM(4), .ID_W(2), .DATA_LEN(32)) bus();

    fifo_flush_arbiter #(
        .REQ_NUM(4), .ID_W(2), .DATA_LEN(32), .FLUSH_HOLD(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- FIFO model (depth 8, full at 7 entries) -------------
    logic [31:0] r_mem [8];
    logic [2:0]  r_wp;
    logic [2:0]  r_rp;
    logic [3:0]  r_cnt;
    logic        w_push;
    logic        w_pop;

    assign w_push         = bus.fifo_wen && (r_cnt != 4'd7);
    assign w_pop          = bus.fifo_ren && (r_cnt != 4'd0);
    assign bus.fifo_rdata = r_mem[r_rp];
    assign bus.fifo_full  = (r_cnt == 4'd7);
    assign bus.fifo_empty = (r_cnt == 4'd0);

    always @(posedge clk) begin
        if (rst || bus.fifo_flush) begin
            r_wp  <= 3'd0;
            r_rp  <= 3'd0;
            r_cnt <= 4'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= bus.fifo_wdata;
                r_wp        <= r_wp + 3'd1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 3'd1;
            end
            r_cnt <= r_cnt + {3'd0, w_push} - {3'd0, w_pop};
        end
    end

    // ---------------- helpers ----------------------------------------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_data(input int idx, input logic [31:0] val);
        bus.req_data[idx*32 +: 32] = val;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int exp_g [3] = '{3, 1, 3};
    logic [31:0] exp_d3 [3] = '{32'hC3, 32'hC1, 32'hC3};
    logic [31:0] exp_drain [4] = '{32'hC3, 32'hC1, 32'hC3, 32'hD0};

    initial begin
        bus.flush_req = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;

        // ---- reset state ----
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_wen",   32'(bus.fifo_wen), 0);
        chk("rst_ren",   32'(bus.fifo_ren), 0);
        chk("rst_flush", 32'(bus.fifo_flush), 0);
        chk("rst_busy",  32'(bus.busy), 0);
        chk("rst_oval",  32'(bus.out_valid), 0);
`ifdef FIFO_FLUSH_ARB_PERF_EN
        chk("rst_pflush", 32'(bus.perf_flush_cnt), 0);
        chk("rst_pstall", bus.perf_stall_cnt, 0);
`endif

        // ---- 1: all valid, grants 0..3 in order ----
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_data(i, 32'hA0 + 32'(i));
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t1_gnt",   32'(bus.grant_id), 32'(k));
            chk("t1_ready", 32'(bus.req_ready), 32'(1 << k));
            chk("t1_wdata", bus.fifo_wdata, 32'hA0 + 32'(k));
            cyc();
        end
        bus.req_valid = 4'b0000;

        // drain in order A0..A3
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rd_ren",  32'(bus.fifo_ren), 1);
            chk("rd_data", bus.out_data, 32'hA0 + 32'(k));
            cyc();
        end
        #1;
        chk("rd_empty_oval", 32'(bus.out_valid), 0);
        bus.out_ready = 1'b0;

        // rr_ptr is 0 after test 1, so a single requester 1 wins and rr_ptr becomes 2
        bus.req_valid = 4'b0010;
        set_data(1, 32'hB1);
        #1;
        chk("setup_gnt", 32'(bus.grant_id), 1);
        cyc();

        // ---- 2: sparse valid 1010 from rr_ptr=2 -> 3,1,3 ----
        bus.req_valid = 4'b1010;
        set_data(1, 32'hC1);
        set_data(3, 32'hC3);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t2_gnt",   32'(bus.grant_id), 32'(exp_g[k]));
            chk("t2_ready", 32'(bus.req_ready), 32'(1 << exp_g[k]));
            chk("t2_wdata", bus.fifo_wdata, exp_d3[k]);
            cyc();
        end
        // FIFO: B1 C3 C1 C3, rr_ptr=0

        // ---- 3: fill to full, pop while full, write resumes ----
        bus.req_valid = 4'b0001;
        set_data(0, 32'hD0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_wen", 32'(bus.fifo_wen), 1);
            chk("t3_gnt", 32'(bus.grant_id), 0);
            cyc();
        end
        #1;
        chk("t3_full_wen",   32'(bus.fifo_wen), 0);
        chk("t3_full_ready", 32'(bus.req_ready), 0);
        bus.out_ready = 1'b1;
        #1;
        chk("t3_pop_wen",  32'(bus.fifo_wen), 0);
        chk("t3_pop_ren",  32'(bus.fifo_ren), 1);
        chk("t3_pop_data", bus.out_data, 32'hB1);
        cyc();
        bus.out_ready = 1'b0;
        #1;
        chk("t3_resume_wen",   32'(bus.fifo_wen), 1);
        chk("t3_resume_ready", 32'(bus.req_ready), 32'h1);
        cyc();
        bus.req_valid = 4'b0000;
        // FIFO: C3 C1 C3 D0 D0 D0 D0, rr_ptr=1; drain 4 to leave 3 entries
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t3_drain", bus.out_data, exp_drain[k]);
            cyc();
        end

        // ---- 4: flush pulse with 3 entries queued, FLUSH_HOLD=2 ----
        bus.req_valid = 4'b1111;
        set_data(0, 32'hE0);
        set_data(1, 32'h11);
        set_data(2, 32'h22);
        set_data(3, 32'h55);
        bus.flush_req = 1'b1;
        #1;
        chk("t4_req_wen",   32'(bus.fifo_wen), 0);
        chk("t4_req_ren",   32'(bus.fifo_ren), 0);
        chk("t4_req_oval",  32'(bus.out_valid), 0);
        chk("t4_req_ready", 32'(bus.req_ready), 0);
        chk("t4_req_flush", 32'(bus.fifo_flush), 0);
        chk("t4_req_busy",  32'(bus.busy), 0);
        cyc();
        bus.flush_req = 1'b0;
        #1;
        chk("t4_fl_flush", 32'(bus.fifo_flush), 1);
        chk("t4_fl_busy",  32'(bus.busy), 1);
        chk("t4_fl_wen",   32'(bus.fifo_wen), 0);
        chk("t4_fl_oval",  32'(bus.out_valid), 0);
        cyc();
        #1;
        chk("t4_h1_flush", 32'(bus.fifo_flush), 0);
        chk("t4_h1_busy",  32'(bus.busy), 1);
        chk("t4_h1_wen",   32'(bus.fifo_wen), 0);
        chk("t4_h1_empty", 32'(bus.fifo_empty), 1);
        cyc();
        #1;
        chk("t4_h2_busy", 32'(bus.busy), 1);
        chk("t4_h2_wen",  32'(bus.fifo_wen), 0);
        cyc();
        bus.out_ready = 1'b0;
        #1;
        chk("t4_run_busy",  32'(bus.busy), 0);
        chk("t4_run_wen",   32'(bus.fifo_wen), 1);
        chk("t4_run_gnt",   32'(bus.grant_id), 1);
        chk("t4_run_wdata", bus.fifo_wdata, 32'h11);
        cyc();
        #1;
        chk("t4_next_gnt", 32'(bus.grant_id), 2);
        chk("t4_next_out", bus.out_data, 32'h11);
        cyc();

        // ---- 6: simultaneous push 0x55 / pop 0x11 ----
        bus.req_valid = 4'b1000;
        bus.out_ready = 1'b1;
        #1;
        chk("t6_wen",   32'(bus.fifo_wen), 1);
        chk("t6_ren",   32'(bus.fifo_ren), 1);
        chk("t6_gnt",   32'(bus.grant_id), 3);
        chk("t6_wdata", bus.fifo_wdata, 32'h55);
        chk("t6_head",  bus.out_data, 32'h11);
        cyc();
        bus.req_valid = 4'b0000;
        bus.out_ready = 1'b0;
        #1;
        chk("t6_next_oval", 32'(bus.out_valid), 1);
        chk("t6_next_head", bus.out_data, 32'h22);
        chk("t6_occupancy", 32'(r_cnt), 2);
        cyc();

        // ---- 5: flush re-requested in HOLD cycle 1 (from fresh reset) ----
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.flush_req = 1'b1;
        cyc();
        bus.flush_req = 1'b0;
        #1;
        chk("t5_fl1", 32'(bus.fifo_flush), 1);
        cyc();
        bus.flush_req = 1'b1;
        #1;
        chk("t5_h1_busy",  32'(bus.busy), 1);
        chk("t5_h1_flush", 32'(bus.fifo_flush), 0);
        cyc();
        bus.flush_req = 1'b0;
        #1;
        chk("t5_fl2", 32'(bus.fifo_flush), 1);
        cyc();
        #1;
        chk("t5_h1b_busy", 32'(bus.busy), 1);
        cyc();
        #1;
        chk("t5_h2b_busy", 32'(bus.busy), 1);
        cyc();
        #1;
        chk("t5_run_busy", 32'(bus.busy), 0);
`ifdef FIFO_FLUSH_ARB_PERF_EN
        chk("t5_pflush", 32'(bus.perf_flush_cnt), 2);
`endif

        // ---- reset in the middle of FLUSH: back to RUN, no further flush ----
        bus.flush_req = 1'b1;
        cyc();
        bus.flush_req = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("rstmid_busy",  32'(bus.busy), 0);
        chk("rstmid_flush", 32'(bus.fifo_flush), 0);
        cyc();
        #1;
        chk("rstmid_flush2", 32'(bus.fifo_flush), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
